esc_ping_sched: RTL and testbench
=================================

Name: esc_ping_sched

Overview:
- Schedules periodic ping requests across N escalation sender instances. One ping is outstanding at a time, issued round-robin to each sender's ping_en_i.
- Monitors each sender's ping_ok_o response and flags a timeout when no response arrives in time.
- Sits between the alert/escalation configuration logic and a bank of escalation senders. Keeps every sender/receiver link exercised while escalation is idle.

Parameters:
- N, 4: number of escalation senders scheduled (1..32).
- CntDw, 16: width of the wait and timeout counters and their config inputs.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- en_i  in  1  pinging enabled; low forces IDLE.
- wait_cyc_i  in  CntDw  idle cycles between pings (0 treated as 1).
- timeout_cyc_i  in  CntDw  max cycles a ping may stay unanswered (0 treated as 1).
- esc_en_i  in  N  escalation currently active on sender k (k is skipped and aborted).
- ping_ok_i  in  N  one-cycle ack pulses from senders' ping_ok_o.
- ping_en_o  out  N  ping request per sender; at most one bit high; held until resolved.
- ping_timeout_o  out  1  one-cycle pulse on timeout.
- timeout_idx_o  out  $clog2(N) (min 1)  index that timed out; valid with ping_timeout_o, holds last value otherwise.

Behaviour:
- Reset values: all outputs 0, state IDLE, pointer 0, counters 0.
- Shared-package enum states: IDLE, WAIT, SELECT, PING.
- IDLE:
  - ping_en_o = 0.
  - en_i=1 -> WAIT with cnt=0.
- WAIT:
  - cnt increments each cycle.
  - When cnt+1 >= max(wait_cyc_i,1) -> SELECT.
  - wait_cyc_i=1 gives exactly 1 WAIT cycle.
- SELECT (1 cycle, combinational pick):
  - Pick the first index k at or after ptr (wrapping modulo N) with esc_en_i[k]=0.
  - If found: ptr<=k, cnt<=0 -> PING.
  - If all N are escalating: -> WAIT, cnt=0, ptr unchanged.
- PING:
  - ping_en_o[ptr]=1 from the first PING cycle.
  - cnt counts PING cycles; the first PING cycle is cnt=0.
  - Resolution priority, highest first:
    - (a) esc_en_i[ptr]=1: abort. ping_en_o drops next cycle; no timeout; ptr<=ptr+1 mod N; -> WAIT.
    - (b) ping_ok_i[ptr]=1: success. ptr<=ptr+1 mod N; -> WAIT.
    - (c) cnt+1 >= max(timeout_cyc_i,1): ping_timeout_o=1 for exactly one cycle (registered, cycle after the last PING cycle); timeout_idx_o<=ptr; ptr advances; -> WAIT.
  - ping_ok_i on any other index is ignored in all states.
- ptr wraps N-1 -> 0. N non-power-of-two must wrap correctly.
- en_i=0 in any state -> IDLE next cycle. ping_en_o all 0 from that cycle (registered). Counters cleared; ptr retained; pending timeout pulse suppressed.
- Config inputs are sampled every cycle. Changing them mid-count takes effect immediately via the >= compare; no wrap-around.
- Counters saturate at 2^CntDw-1.
- ping_en_o is registered, no glitches. The protocol requires ping_en held stable until ack.
- Async reset mid-PING: ping_en_o drops immediately, state IDLE.

Decomposition:
- Package esc_ping_sched_pkg: state enum (4 states, 2-bit encoding), plus a function computing the next non-escalating index.
- One sub-module, esc_ping_rr_sel: combinational round-robin picker.
  - Inputs: ptr, esc_en mask.
  - Outputs: sel_idx, sel_valid.
  - Reusable by other schedulers.

Test Plan:
- Basic rotation. N=4, wait=3, timeout=10; senders ack 2 cycles after ping_en rises -> ping_en_o sequence 0001, 0010, 0100, 1000, 0001; no ping_timeout_o.
- Timeout. wait=2, timeout=5; sender 1 never acks -> ping_en_o[1] high exactly 5 cycles, then one-cycle ping_timeout_o with timeout_idx_o=1; next ping goes to sender 2.
- Escalation skip and abort:
  - esc_en_i=4'b0010 constant -> index 1 never pinged; order 0, 2, 3, 0.
  - esc_en_i[2] rising mid-ping to 2 -> abort, no timeout, next ping to 3.
- All escalating. esc_en_i=4'b1111 for 50 cycles -> ping_en_o stays 0, no timeout. Release -> ping resumes at the retained ptr.
- Disable mid-ping. en_i=0 at PING cycle 2 -> ping_en_o=0 next cycle, no timeout pulse. Re-enable -> same index pinged after wait_cyc_i.
- Edge config. wait=0, timeout=0, N=3, no acks -> ping_en_o high 1 cycle each; timeout pulses for idx 0, 1, 2, 0; ptr wraps 2->0.

Source files
------------

// File: rtl/esc_ping_sched_pkg.sv
// Shared types and helpers for the escalation ping scheduler.
// Provides the scheduler state encoding and a round-robin pick over an escalation mask.
package esc_ping_sched_pkg;

    localparam int unsigned MaxN    = 32;
    localparam int unsigned MaxIdxW = 5;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StSelect,
        StPing
    } state_e;

    typedef struct packed {
        logic               valid;
        logic [MaxIdxW-1:0] idx;
    } rr_pick_t;

    // First index at or after ptr (modulo n) whose escalation bit is clear.
    function automatic rr_pick_t rr_next_idx(input logic [MaxN-1:0]    esc_en,
                                             input logic [MaxIdxW-1:0] ptr,
                                             input logic [MaxIdxW:0]   n);
        rr_pick_t           pick;
        logic [MaxIdxW:0]   k;
        pick = '0;
        for (int unsigned i = 0; i < MaxN; i++) begin
            k = {1'b0, ptr} + (MaxIdxW + 1)'(i);
            if (k >= n) begin
                k = k - n;
            end
            if (((MaxIdxW + 1)'(i) < n) && !pick.valid && !esc_en[k[MaxIdxW-1:0]]) begin
                pick.valid = 1'b1;
                pick.idx   = k[MaxIdxW-1:0];
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/esc_ping_rr_sel.sv
// Combinational round-robin picker: first non-escalating sender at or after ptr_i.
// Purely combinational so any scheduler can register the result as it sees fit.
module esc_ping_rr_sel
    import esc_ping_sched_pkg::*;
#(
    parameter int unsigned N = 4,
    localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [IdxW-1:0] ptr_i,
    input  logic [N-1:0]    esc_en_i,
    output logic [IdxW-1:0] sel_idx_o,
    output logic            sel_valid_o
);

    rr_pick_t pick;
    logic     unused_idx;

    assign pick        = rr_next_idx(MaxN'(esc_en_i), MaxIdxW'(ptr_i), (MaxIdxW + 1)'(N));
    assign sel_valid_o = pick.valid;
    assign sel_idx_o   = pick.idx[IdxW-1:0];

    // Upper index bits are always zero for N below the package maximum.
    assign unused_idx  = ^pick.idx;

endmodule

// File: rtl/esc_ping_sched.sv
// Round-robin ping scheduler for a bank of escalation senders.
// One ping outstanding at a time; flags a one-cycle timeout when a sender fails to answer.
module esc_ping_sched
    import esc_ping_sched_pkg::*;
#(
    parameter int unsigned N     = 4,
    parameter int unsigned CntDw = 16,
    localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic [CntDw-1:0] wait_cyc_i,
    input  logic [CntDw-1:0] timeout_cyc_i,
    input  logic [N-1:0]     esc_en_i,
    input  logic [N-1:0]     ping_ok_i,
    output logic [N-1:0]     ping_en_o,
    output logic             ping_timeout_o,
    output logic [IdxW-1:0]  timeout_idx_o
);

    state_e           state_q, state_d;
    logic [CntDw-1:0] cnt_q, cnt_d, cnt_sat;
    logic [CntDw:0]   cnt_inc, wait_thr, to_thr;
    logic [IdxW-1:0]  ptr_q, ptr_d, ptr_inc;
    logic [IdxW-1:0]  sel_idx;
    logic             sel_valid;
    logic [N-1:0]     ping_en_q, ping_en_d;
    logic             timeout_q, timeout_d;
    logic [IdxW-1:0]  timeout_idx_q, timeout_idx_d;

    esc_ping_rr_sel #(
        .N (N)
    ) u_rr_sel (
        .ptr_i       (ptr_q),
        .esc_en_i    (esc_en_i),
        .sel_idx_o   (sel_idx),
        .sel_valid_o (sel_valid)
    );

    // One extra bit keeps cnt+1 from wrapping before the threshold compare.
    assign cnt_inc  = {1'b0, cnt_q} + (CntDw + 1)'(1);
    assign cnt_sat  = (&cnt_q) ? cnt_q : cnt_inc[CntDw-1:0];
    assign wait_thr = (wait_cyc_i == '0) ? (CntDw + 1)'(1) : {1'b0, wait_cyc_i};
    assign to_thr   = (timeout_cyc_i == '0) ? (CntDw + 1)'(1) : {1'b0, timeout_cyc_i};
    assign ptr_inc  = (ptr_q == IdxW'(N - 1)) ? '0 : ptr_q + IdxW'(1);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        ptr_d         = ptr_q;
        timeout_d     = 1'b0;
        timeout_idx_d = timeout_idx_q;
        ping_en_d     = '0;

        case (state_q)
            StIdle: begin
                if (en_i) begin
                    state_d = StWait;
                    cnt_d   = '0;
                end
            end
            StWait: begin
                if (cnt_inc >= wait_thr) begin
                    state_d = StSelect;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_sat;
                end
            end
            StSelect: begin
                cnt_d = '0;
                if (sel_valid) begin
                    ptr_d   = sel_idx;
                    state_d = StPing;
                end else begin
                    state_d = StWait;
                end
            end
            StPing: begin
                if (esc_en_i[ptr_q] || ping_ok_i[ptr_q]) begin
                    ptr_d   = ptr_inc;
                    cnt_d   = '0;
                    state_d = StWait;
                end else if (cnt_inc >= to_thr) begin
                    timeout_d     = 1'b1;
                    timeout_idx_d = ptr_q;
                    ptr_d         = ptr_inc;
                    cnt_d         = '0;
                    state_d       = StWait;
                end else begin
                    cnt_d = cnt_sat;
                end
            end
            default: state_d = StIdle;
        endcase

        // Disable wins over everything, including a timeout due this cycle.
        if (!en_i) begin
            state_d       = StIdle;
            cnt_d         = '0;
            timeout_d     = 1'b0;
            timeout_idx_d = timeout_idx_q;
        end

        if (state_d == StPing) begin
            ping_en_d[ptr_d] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            ptr_q         <= '0;
            ping_en_q     <= '0;
            timeout_q     <= 1'b0;
            timeout_idx_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            ptr_q         <= ptr_d;
            ping_en_q     <= ping_en_d;
            timeout_q     <= timeout_d;
            timeout_idx_q <= timeout_idx_d;
        end
    end

    assign ping_en_o      = ping_en_q;
    assign ping_timeout_o = timeout_q;
    assign timeout_idx_o  = timeout_idx_q;

endmodule

// File: tb/tb_esc_ping_sched.sv
// Directed bench for esc_ping_sched: table-driven rotation scenarios on N=4 plus
// hand-written abort, all-escalating, disable, async reset and N=3 edge-config sequences.
module tb_esc_ping_sched;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // N=4 instance
    logic        en4;
    logic [15:0] wait4, to4;
    logic [3:0]  esc4, ok4, ping4;
    logic        to_p4;
    logic [1:0]  idx4;

    // N=3 instance
    logic        en3;
    logic [15:0] wait3, to3;
    logic [2:0]  esc3, ok3, ping3;
    logic        to_p3;
    logic [1:0]  idx3;

    esc_ping_sched #(
        .N     (4),
        .CntDw (16)
    ) dut4 (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .en_i           (en4),
        .wait_cyc_i     (wait4),
        .timeout_cyc_i  (to4),
        .esc_en_i       (esc4),
        .ping_ok_i      (ok4),
        .ping_en_o      (ping4),
        .ping_timeout_o (to_p4),
        .timeout_idx_o  (idx4)
    );

    esc_ping_sched #(
        .N     (3),
        .CntDw (16)
    ) dut3 (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .en_i           (en3),
        .wait_cyc_i     (wait3),
        .timeout_cyc_i  (to3),
        .esc_en_i       (esc3),
        .ping_ok_i      (ok3),
        .ping_en_o      (ping3),
        .ping_timeout_o (to_p3),
        .timeout_idx_o  (idx3)
    );

    int n_checks = 0;
    int n_fail   = 0;

    int ping_log[$];
    int to_log[$];
    int dur_log[$];

    logic [3:0] ack_en;
    int         ack_delay = 2;
    logic [3:0] prev_ping;
    logic       prev_to;
    int         cur_dur;

    typedef struct packed {
        logic [15:0]     wait_c;
        logic [15:0]     to_c;
        logic [3:0]      esc;
        logic [3:0]      ack_en;
        logic [4:0][1:0] exp_seq;
        int              exp_to_n;
        int              exp_to_first;
        int              exp_dur1;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic int idx_of(input logic [3:0] v);
        for (int i = 0; i < 4; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    // One clock: sample dut4 just after the edge, log pings/timeouts, model the senders.
    task automatic step();
        @(posedge clk);
        #1;
        if (ping4 != 4'b0 && ping4 != prev_ping) begin
            ping_log.push_back(idx_of(ping4));
            cur_dur = 0;
        end
        if (ping4 != 4'b0) cur_dur++;
        if (ping4 == 4'b0 && prev_ping != 4'b0) dur_log.push_back(cur_dur);
        check("ping_onehot", int'($countones(ping4) <= 1), 1);
        if (to_p4) begin
            to_log.push_back(int'(idx4));
            check("timeout_align", int'({prev_ping == (4'b1 << idx4), ping4 == 4'b0, prev_to}),
                  int'(3'b110));
        end
        ok4 = (ping4 != 4'b0 && cur_dur == ack_delay) ? (ping4 & ack_en) : 4'b0;
        prev_ping = ping4;
        prev_to   = to_p4;
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        en4 = 1'b0; esc4 = '0; ok4 = '0; wait4 = '0; to4 = '0; ack_en = '0;
        en3 = 1'b0; esc3 = '0; ok3 = '0; wait3 = '0; to3 = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset_ping4", int'(ping4), 0);
        check("reset_to4", int'({to_p4, idx4}), 0);
        check("reset_ping3", int'({ping3, to_p3, idx3}), 0);
        ping_log.delete();
        to_log.delete();
        dur_log.delete();
        prev_ping = '0;
        prev_to   = 1'b0;
        cur_dur   = 0;
        rst_n     = 1'b1;
    endtask

    task automatic wait_pings(input string name, input int n);
        for (int c = 0; c < 400 && ping_log.size() < n; c++) step();
        check(name, int'(ping_log.size() >= n), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        vecs[0] = '{wait_c: 16'd3, to_c: 16'd10, esc: 4'b0000, ack_en: 4'b1111,
                    exp_seq: {2'd0, 2'd3, 2'd2, 2'd1, 2'd0},
                    exp_to_n: 0, exp_to_first: 0, exp_dur1: 2};
        vecs[1] = '{wait_c: 16'd2, to_c: 16'd5, esc: 4'b0000, ack_en: 4'b1101,
                    exp_seq: {2'd0, 2'd3, 2'd2, 2'd1, 2'd0},
                    exp_to_n: 1, exp_to_first: 1, exp_dur1: 5};
        vecs[2] = '{wait_c: 16'd3, to_c: 16'd10, esc: 4'b0010, ack_en: 4'b1111,
                    exp_seq: {2'd2, 2'd0, 2'd3, 2'd2, 2'd0},
                    exp_to_n: 0, exp_to_first: 0, exp_dur1: 2};
        vecs[3] = '{wait_c: 16'd1, to_c: 16'd3, esc: 4'b0000, ack_en: 4'b0000,
                    exp_seq: {2'd0, 2'd3, 2'd2, 2'd1, 2'd0},
                    exp_to_n: 4, exp_to_first: 0, exp_dur1: 3};

        // Table-driven rotation scenarios.
        for (int v = 0; v < 4; v++) begin
            reset_dut();
            wait4  = vecs[v].wait_c;
            to4    = vecs[v].to_c;
            esc4   = vecs[v].esc;
            ack_en = vecs[v].ack_en;
            en4    = 1'b1;
            wait_pings($sformatf("vec%0d_npings", v), 5);
            for (int i = 0; i < 5 && i < ping_log.size(); i++) begin
                check($sformatf("vec%0d_seq%0d", v, i), ping_log[i], int'(vecs[v].exp_seq[i]));
            end
            check($sformatf("vec%0d_ntimeouts", v), to_log.size(), vecs[v].exp_to_n);
            if (vecs[v].exp_to_n > 0 && to_log.size() > 0) begin
                check($sformatf("vec%0d_to_idx", v), to_log[0], vecs[v].exp_to_first);
            end
            check($sformatf("vec%0d_dur_ndrops", v), int'(dur_log.size() >= 2), 1);
            if (dur_log.size() >= 2) begin
                check($sformatf("vec%0d_dur1", v), dur_log[1], vecs[v].exp_dur1);
            end
        end

        // Escalation rising mid-ping aborts without timeout; next ping goes to 3.
        reset_dut();
        wait4 = 16'd3; to4 = 16'd10; ack_en = 4'b1011; en4 = 1'b1;
        for (int c = 0; c < 400 && ping4 != 4'b0100; c++) step();
        check("abort_reach_idx2", int'(ping4), int'(4'b0100));
        step();
        step();
        esc4 = 4'b0100;
        step();
        check("abort_drop", int'(ping4), 0);
        check("abort_no_timeout_pulse", int'(to_p4), 0);
        base = ping_log.size();
        wait_pings("abort_next_ping", base + 1);
        if (ping_log.size() > base) check("abort_next_idx", ping_log[base], 3);
        check("abort_no_timeouts", to_log.size(), 0);

        // All escalating: nothing is pinged, then resume at the retained pointer.
        reset_dut();
        wait4 = 16'd2; to4 = 16'd10; ack_en = 4'b1111; en4 = 1'b1;
        for (int c = 0; c < 400 && dur_log.size() < 2; c++) step();
        check("allesc_two_done", dur_log.size(), 2);
        esc4 = 4'b1111;
        for (int c = 0; c < 50; c++) step();
        check("allesc_no_pings", ping_log.size(), 2);
        check("allesc_no_timeouts", to_log.size(), 0);
        check("allesc_ping_low", int'(ping4), 0);
        esc4 = 4'b0000;
        wait_pings("allesc_resume", 3);
        if (ping_log.size() > 2) check("allesc_resume_idx", ping_log[2], 2);

        // Disable during the second PING cycle, then re-enable.
        reset_dut();
        wait4 = 16'd3; to4 = 16'd10; ack_en = 4'b0000; en4 = 1'b1;
        wait_pings("dis_first_ping", 1);
        step();
        en4 = 1'b0;
        step();
        check("dis_drop", int'(ping4), 0);
        step();
        step();
        check("dis_no_timeouts", to_log.size(), 0);
        en4 = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            step();
            if (k == 4) check("reen_before", int'(ping4), 0);
            if (k == 5) check("reen_ping0", int'(ping4), int'(4'b0001));
        end

        // Asynchronous reset while pinging drops ping_en without a clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_drop", int'(ping4), 0);

        // N=3 with zero config: one-cycle pings, a timeout per index, pointer wraps.
        reset_dut();
        wait3 = 16'd0; to3 = 16'd0; en3 = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            int exp_ping, exp_to, exp_idx;
            step();
            exp_ping = (k % 3 == 0) ? (1 << ((k / 3 - 1) % 3)) : 0;
            exp_to   = (k >= 4 && k % 3 == 1) ? 1 : 0;
            exp_idx  = ((k - 4) / 3) % 3;
            check($sformatf("n3_ping_k%0d", k), int'(ping3), exp_ping);
            check($sformatf("n3_to_k%0d", k), int'(to_p3), exp_to);
            if (exp_to == 1) check($sformatf("n3_idx_k%0d", k), int'(idx3), exp_idx);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
